hpm_counters_gen: RTL and testbench

- Parametrised hardware performance monitor, successor to the fixed 29-counter HPM block.
- Sits beside the CSR file and serves mhpmcounter3.., mhpmevent3.. and mcountinhibit accesses.
- Adds parametrised width, counter count and event count.
- Adds per-counter inhibit, privilege-mode filtering, and sticky overflow flags with an overflow interrupt request (Sscofpmf-style).

---
 rtl/hpm_counters_gen.sv | 74 +++++++
 tb/tb_hpm_counters_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hpm_counters_gen.sv
// hpm_counters_gen: parametrised HPM counters with event select, mode filtering, inhibit and sticky overflow irq
module hpm_counters_gen #(
  parameter int          NUM_COUNTERS = 29,
  parameter int          NUM_EVENTS   = 32,
  parameter int          CNT_WIDTH    = 64,
  parameter int          SEL_WIDTH    = 8,
  parameter logic [11:0] CNT_BASE     = 12'hB03,
  parameter logic [11:0] EVT_BASE     = 12'h323,
  parameter logic [11:0] INH_ADDR     = 12'h320
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [11:0]           addr_i,
  input  logic                  we_i,
  input  logic [63:0]           data_i,
  output logic [63:0]           data_o,
  input  logic [1:0]            priv_i,
  input  logic [NUM_EVENTS-1:0] events_i,
  output logic                  ovf_irq_o
);
  localparam int EW = 2 ** SEL_WIDTH;
  logic [CNT_WIDTH-1:0]    cnt [NUM_COUNTERS];
  logic [SEL_WIDTH-1:0]    sel [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] of, minh, sinh, uinh, inh, wr_c, wr_e, inc, wrap;
  logic [EW-1:0]           ev;
  assign ev = EW'({events_i, 1'b0});
  always_comb begin
    wr_c = '0;
    wr_e = '0;
    inc  = '0;
    wrap = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      wr_c[i] = we_i && addr_i == 12'(CNT_BASE + i);
      wr_e[i] = we_i && addr_i == 12'(EVT_BASE + i);
      inc[i]  = ev[sel[i]] && !inh[i] && !wr_c[i] &&
                !(priv_i == 2'd0 ? uinh[i] : priv_i == 2'd1 ? sinh[i] : minh[i]);
      wrap[i] = inc[i] && &cnt[i];
    end
  end
  always_comb begin
    data_o = addr_i == INH_ADDR ? 64'({inh, 3'b000}) : '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (addr_i == 12'(CNT_BASE + i)) data_o = 64'(cnt[i]);
      if (addr_i == 12'(EVT_BASE + i)) data_o = {of[i], minh[i], sinh[i], uinh[i], 60'(sel[i])};
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt[i] <= '0;
        sel[i] <= '0;
      end
      of        <= '0;
      minh      <= '0;
      sinh      <= '0;
      uinh      <= '0;
      inh       <= '0;
      ovf_irq_o <= 1'b0;
    end else begin
      ovf_irq_o <= |of;
      if (we_i && addr_i == INH_ADDR) inh <= data_i[NUM_COUNTERS+2:3];
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt[i] <= wr_c[i] ? data_i[CNT_WIDTH-1:0] : cnt[i] + CNT_WIDTH'(inc[i]);
        of[i]  <= wrap[i] | (wr_e[i] ? data_i[63] : of[i]);
        if (wr_e[i]) begin
          sel[i]  <= data_i[SEL_WIDTH-1:0];
          minh[i] <= data_i[62];
          sinh[i] <= data_i[61];
          uinh[i] <= data_i[60];
        end
      end
    end
  end
endmodule

// File: tb/tb_hpm_counters_gen.sv
// tb_hpm_counters_gen: vector table, directed corner sequences and randomized checks against a behavioural model
module tb_hpm_counters_gen;
  localparam int          NC = 4;
  localparam int          NE = 8;
  localparam int          CW = 8;
  localparam int          SW = 4;
  localparam logic [11:0] CB = 12'hB03;
  localparam logic [11:0] EB = 12'h323;
  localparam logic [11:0] IA = 12'h320;
  logic          clk_i = 1'b0;
  logic          rst_i, we_i, ovf_irq_o;
  logic [11:0]   addr_i;
  logic [63:0]   data_i, data_o;
  logic [1:0]    priv_i;
  logic [NE-1:0] events_i;
  int errors = 0;
  int checks = 0;
  always #5 clk_i = ~clk_i;
  hpm_counters_gen #(
    .NUM_COUNTERS(NC), .NUM_EVENTS(NE), .CNT_WIDTH(CW), .SEL_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .we_i(we_i), .data_i(data_i),
    .data_o(data_o), .priv_i(priv_i), .events_i(events_i), .ovf_irq_o(ovf_irq_o)
  );
  int       m_cnt [NC];
  bit [3:0] m_sel [NC];
  bit       m_of [NC], m_mi [NC], m_si [NC], m_ui [NC], m_inh [NC];
  bit       m_irq;
  task automatic mstep();
    bit any, on, blk, wc, inc, wrp;
    if (rst_i) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = 0; m_sel[i] = 0; m_of[i] = 0;
        m_mi[i] = 0; m_si[i] = 0; m_ui[i] = 0; m_inh[i] = 0;
      end
      m_irq = 0;
    end else begin
      any = 0;
      for (int i = 0; i < NC; i++) any |= m_of[i];
      for (int i = 0; i < NC; i++) begin
        on  = (m_sel[i] >= 1 && m_sel[i] <= NE) ? events_i[m_sel[i] - 1] : 1'b0;
        blk = m_inh[i] || (priv_i == 0 ? m_ui[i] : priv_i == 1 ? m_si[i] : m_mi[i]);
        wc  = we_i && addr_i == 12'(CB + i);
        inc = on && !blk && !wc;
        wrp = inc && m_cnt[i] == (1 << CW) - 1;
        if (wc) m_cnt[i] = int'(data_i[CW-1:0]);
        else if (inc) m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
        if (we_i && addr_i == 12'(EB + i)) begin
          m_sel[i] = data_i[3:0];
          m_mi[i]  = data_i[62];
          m_si[i]  = data_i[61];
          m_ui[i]  = data_i[60];
          m_of[i]  = data_i[63] || wrp;
        end else if (wrp) m_of[i] = 1;
      end
      if (we_i && addr_i == IA) for (int i = 0; i < NC; i++) m_inh[i] = data_i[i+3];
      m_irq = any;
    end
  endtask
  always @(posedge clk_i) mstep();
  function automatic logic [63:0] mread(logic [11:0] a);
    logic [63:0] r = '0;
    for (int i = 0; i < NC; i++) begin
      if (a == 12'(CB + i)) r = 64'(m_cnt[i]);
      if (a == 12'(EB + i)) r = {m_of[i], m_mi[i], m_si[i], m_ui[i], 56'd0, m_sel[i]};
      if (a == IA) r[i+3] = m_inh[i];
    end
    return r;
  endfunction
  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic rd(string n, logic [11:0] a, logic [63:0] e);
    we_i = 1'b0;
    addr_i = a;
    #1;
    check(n, data_o, e);
  endtask
  task automatic wr(logic [11:0] a, logic [63:0] d);
    we_i = 1'b1;
    addr_i = a;
    data_i = d;
    tick();
    we_i = 1'b0;
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    we_i = 1'b0;
    events_i = '0;
    tick();
    rst_i = 1'b0;
  endtask
  typedef struct {
    logic        rst;
    logic        we;
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  ev;
    logic [1:0]  priv;
    logic [11:0] raddr;
    logic [63:0] exp;
    logic        irq;
  } vec_t;
  vec_t tbl [21];
  initial begin
    tbl[0]  = '{0, 1, EB, 64'd3,     8'h00, 2'd3, EB, 64'd3,     0};
    tbl[1]  = '{0, 1, CB, 64'hFE,    8'h00, 2'd3, CB, 64'hFE,    0};
    tbl[2]  = '{0, 0, CB, 64'd0,     8'h04, 2'd3, CB, 64'hFF,    0};
    tbl[3]  = '{0, 0, CB, 64'd0,     8'h04, 2'd3, CB, 64'h00,    0};
    tbl[4]  = '{0, 0, CB, 64'd0,     8'h00, 2'd3, EB, 64'h8000_0000_0000_0003, 1};
    tbl[5]  = '{0, 1, EB, 64'd3,     8'h00, 2'd3, EB, 64'd3,     1};
    tbl[6]  = '{0, 0, CB, 64'd0,     8'h00, 2'd3, EB, 64'd3,     0};
    tbl[7]  = '{0, 1, EB, 64'h1000_0000_0000_0003, 8'h00, 2'd3, EB, 64'h1000_0000_0000_0003, 0};
    for (int k = 0; k < 8; k++)
      tbl[8+k] = '{0, 0, CB, 64'd0, 8'h04, (k % 2 == 0) ? 2'd0 : 2'd3, CB, 64'((k + 1) / 2), 0};
    tbl[16] = '{0, 1, IA, 64'd8,     8'h04, 2'd3, IA, 64'd8,     0};
    tbl[17] = '{0, 0, CB, 64'd0,     8'h04, 2'd3, CB, 64'd5,     0};
    tbl[18] = '{0, 0, CB, 64'd0,     8'h04, 2'd3, CB, 64'd5,     0};
    tbl[19] = '{1, 1, CB, 64'h55,    8'h04, 2'd3, CB, 64'd0,     0};
    tbl[20] = '{0, 0, CB, 64'd0,     8'h00, 2'd3, IA, 64'd0,     0};
    rst_i = 1'b1;
    we_i = 1'b0;
    addr_i = '0;
    data_i = '0;
    priv_i = 2'd3;
    events_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < NC; i++) begin
      rd($sformatf("rst_cnt%0d", i), 12'(CB + i), 64'd0);
      rd($sformatf("rst_evt%0d", i), 12'(EB + i), 64'd0);
    end
    rd("rst_inh", IA, 64'd0);
    check("rst_irq", 64'(ovf_irq_o), 64'd0);
    for (int k = 0; k < 21; k++) begin
      rst_i = tbl[k].rst;
      we_i = tbl[k].we;
      addr_i = tbl[k].addr;
      data_i = tbl[k].data;
      events_i = tbl[k].ev;
      priv_i = tbl[k].priv;
      tick();
      rst_i = 1'b0;
      rd($sformatf("vec%0d_data", k), tbl[k].raddr, tbl[k].exp);
      check($sformatf("vec%0d_irq", k), 64'(ovf_irq_o), 64'(tbl[k].irq));
    end
    events_i = '0;
    priv_i = 2'd3;
    wr(EB, 64'd3);
    events_i = 8'h04;
    repeat (10) tick();
    events_i = '0;
    rd("count10_c0", CB, 64'd10);
    rd("count10_c1", 12'(CB + 1), 64'd0);
    do_reset();
    wr(EB, 64'd3);
    wr(12'(EB + 1), 64'd3);
    events_i = 8'h04;
    repeat (3) tick();
    wr(CB, 64'd100);
    rd("cwr_c0_a", CB, 64'd100);
    rd("cwr_c1_a", 12'(CB + 1), 64'd4);
    tick();
    rd("cwr_c0_b", CB, 64'd101);
    rd("cwr_c1_b", 12'(CB + 1), 64'd5);
    do_reset();
    wr(EB, 64'h8000_0000_0000_0003);
    wr(CB, 64'hFF);
    events_i = 8'h04;
    wr(EB, 64'd3);
    events_i = '0;
    rd("hwwin_evt", EB, 64'h8000_0000_0000_0003);
    rd("hwwin_cnt", CB, 64'd0);
    check("hwwin_irq_a", 64'(ovf_irq_o), 64'd1);
    tick();
    check("hwwin_irq_b", 64'(ovf_irq_o), 64'd1);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst_i = ($urandom_range(0, 199) == 0);
      we_i = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      addr_i = r < 4 ? 12'(CB + r) : r < 8 ? 12'(EB + r - 4) : r == 8 ? IA : 12'($urandom);
      data_i = {$urandom, $urandom};
      if (r < 4 && $urandom_range(0, 1) == 1) data_i[7:0] = 8'($urandom_range(240, 255));
      if (r >= 4 && r < 8 && $urandom_range(0, 1) == 1) data_i[62:60] = 3'b000;
      events_i = 8'($urandom);
      priv_i = 2'($urandom);
      tick();
      rst_i = 1'b0;
      check($sformatf("rnd%0d_data", n), data_o, mread(addr_i));
      check($sformatf("rnd%0d_irq", n), 64'(ovf_irq_o), 64'(m_irq));
      r = $urandom_range(0, 8);
      rd($sformatf("rnd%0d_rd", n), r < 4 ? 12'(CB + r) : r < 8 ? 12'(EB + r - 4) : IA,
         mread(r < 4 ? 12'(CB + r) : r < 8 ? 12'(EB + r - 4) : IA));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
